fft_ctrl: RTL and testbench

FFT_CTRL -- requirements
Module: fft_ctrl

---
 rtl/fft_ctrl.sv | 138 +++++++++++++
 tb/tb_fft_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_ctrl.sv
// Radix-2 in-place FFT sequencer: walks LOG2N stages of N/2 butterflies each,
// issuing read/launch/write strobes, buffer addresses and twiddle indices.
module fft_ctrl #(
  parameter int LOG2N = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bfly_done,
  output logic             fft_start,
  output logic             sram_read_ena,
  output logic             sram_write_ena,
  output logic [9:0]       address,
  output logic             bfly_start,
  output logic [LOG2N-2:0] twiddle_idx,
  output logic [3:0]       stage,
  output logic             busy,
  output logic             done
);

  localparam int KW = LOG2N - 1;
  localparam int AW = 10;

  typedef enum logic [2:0] {
    IDLE, LOAD, RD_A, RD_B, BFLY, WR_A, WR_B, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    s, s_nxt;
  logic [KW-1:0] k, k_nxt;
  logic          in_bfly;

  logic [AW-1:0] k_w, span, pos, addr_a, addr_b;
  logic [KW-1:0] tw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s       <= '0;
      k       <= '0;
      in_bfly <= 1'b0;
    end else begin
      state   <= state_nxt;
      s       <= s_nxt;
      k       <= k_nxt;
      in_bfly <= (state == BFLY);
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    k_nxt     = k;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        s_nxt     = '0;
        k_nxt     = '0;
        state_nxt = RD_A;
      end
      RD_A: state_nxt = RD_B;
      RD_B: state_nxt = BFLY;
      BFLY: if (bfly_done) state_nxt = WR_A;
      WR_A: state_nxt = WR_B;
      WR_B: begin
        if (k != '1) begin
          k_nxt     = k + 1'b1;
          state_nxt = RD_A;
        end else if (s != 4'(LOG2N - 1)) begin
          k_nxt     = '0;
          s_nxt     = s + 4'd1;
          state_nxt = RD_A;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        s_nxt     = '0;
        k_nxt     = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grp*2*span + pos collapses to 2*k - pos because k = grp*span + pos.
  always_comb begin
    k_w    = AW'(k);
    span   = AW'(1) << s;
    pos    = k_w & (span - AW'(1));
    addr_a = (k_w << 1) - pos;
    addr_b = addr_a + span;
    tw     = pos[KW-1:0] << (4'(KW) - s);
  end

  always_comb begin
    fft_start      = 1'b0;
    sram_read_ena  = 1'b0;
    sram_write_ena = 1'b0;
    address        = '0;
    bfly_start     = 1'b0;
    twiddle_idx    = '0;
    stage          = '0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      LOAD: begin
        fft_start = 1'b1;
        busy      = 1'b1;
        stage     = s;
      end
      RD_A, RD_B: begin
        sram_read_ena = 1'b1;
        address       = (state == RD_A) ? addr_a : addr_b;
        twiddle_idx   = tw;
        busy          = 1'b1;
        stage         = s;
      end
      BFLY: begin
        // Launch only on entry; a stalled butterfly must not be relaunched.
        bfly_start  = !in_bfly;
        twiddle_idx = tw;
        busy        = 1'b1;
        stage       = s;
      end
      WR_A, WR_B: begin
        sram_write_ena = 1'b1;
        address        = (state == WR_A) ? addr_a : addr_b;
        twiddle_idx    = tw;
        busy           = 1'b1;
        stage          = s;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl: stimulus queues the expected strobe stream,
// a negedge monitor pops and compares whenever any strobe is presented.
module tb_fft_ctrl;
  localparam int LOG2N = 9;
  localparam int NB    = (1 << LOG2N) / 2;
  localparam logic [4:0] K_DONE = 5'b10000;
  localparam logic [4:0] K_LOAD = 5'b01000;
  localparam logic [4:0] K_RD   = 5'b00100;
  localparam logic [4:0] K_WR   = 5'b00010;
  localparam logic [4:0] K_BST  = 5'b00001;

  logic       clk = 1'b0;
  logic       rst, start, bfly_done;
  logic       fft_start, sram_read_ena, sram_write_ena, bfly_start, busy, done;
  logic [9:0] address;
  logic [7:0] twiddle_idx;
  logic [3:0] stage;

  always #5 clk = ~clk;

  fft_ctrl #(.LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .start(start), .bfly_done(bfly_done),
    .fft_start(fft_start), .sram_read_ena(sram_read_ena),
    .sram_write_ena(sram_write_ena), .address(address),
    .bfly_start(bfly_start), .twiddle_idx(twiddle_idx), .stage(stage),
    .busy(busy), .done(done)
  );

  typedef struct {
    int         cyc;
    logic [4:0] kind;
    logic [9:0] addr;
    logic [7:0] tw;
    logic [3:0] stg;
    logic       bsy;
    int         hand_addr;
    int         hand_tw;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  tests = 0, fails = 0;
  int  rd_cnt = 0, wr_cnt = 0;
  bit  lo[int];
  bit  pulse_at[int];
  int  stall_of[int];
  int  done_abs, abort_abs;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, logic [4:0] kd, int a, int tw, int stg,
                               logic bsy, int ha, int ht);
    ev_t e;
    e.cyc = c; e.kind = kd; e.addr = 10'(a); e.tw = 8'(tw); e.stg = 4'(stg);
    e.bsy = bsy; e.hand_addr = ha; e.hand_tw = ht;
    q.push_back(e);
  endfunction

  // Expected stream; e is the cycle index in which LOAD is visible.
  task automatic build(input int e, input int abort_b);
    int t, span, pos, grp, a, bb, tw, st, b, ha_a, ha_b, ht;
    lo.delete();
    abort_abs = -1;
    done_abs  = -1;
    push(e, K_LOAD, 0, 0, 0, 1'b1, -1, -1);
    t = 2;
    for (int s = 0; s < LOG2N; s++) begin
      for (int k = 0; k < NB; k++) begin
        b = s * NB + k; span = 1 << s; pos = k % span; grp = k / span;
        a = grp * 2 * span + pos; bb = a + span;
        tw = (pos << (LOG2N - 1 - s)) % NB;
        ha_a = -1; ha_b = -1; ht = -1;
        if (s == 0 && k == 0) begin ha_a = 0; ha_b = 1;   ht = 0;   end
        if (s == 1 && k == 5) begin ha_a = 9; ha_b = 11;  ht = 128; end
        if (s == 8 && k == 3) begin ha_a = 3; ha_b = 259; ht = 3;   end
        push(e + t - 1, K_RD,  a,  tw, s, 1'b1, ha_a, ht);
        push(e + t,     K_RD,  bb, tw, s, 1'b1, ha_b, ht);
        push(e + t + 1, K_BST, 0,  tw, s, 1'b1, -1,   ht);
        st = stall_of.exists(b) ? stall_of[b] : 0;
        for (int i = 0; i < st; i++) lo[e + t + 1 + i] = 1'b1;
        t += st;
        push(e + t + 2, K_WR, a, tw, s, 1'b1, ha_a, ht);
        if (b == abort_b) begin
          abort_abs = e + t + 2;
          return;
        end
        push(e + t + 3, K_WR, bb, tw, s, 1'b1, ha_b, ht);
        t += 5;
      end
    end
    done_abs = e + t - 1;
    push(done_abs, K_DONE, 0, 0, 0, 1'b0, -1, -1);
  endtask

  always @(negedge clk) begin
    logic [4:0] kd;
    ev_t x;
    kd = {done, fft_start, sram_read_ena, sram_write_ena, bfly_start};
    if (kd != 5'b0) begin
      if (sram_read_ena)  rd_cnt++;
      if (sram_write_ena) wr_cnt++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe cyc=%0d kind=%b addr=%0d, nothing expected",
                 cyc, kd, address);
      end else begin
        x = q.pop_front();
        if (cyc !== x.cyc || kd !== x.kind || address !== x.addr ||
            twiddle_idx !== x.tw || stage !== x.stg || busy !== x.bsy) begin
          fails++;
          $display("FAIL event got cyc=%0d kind=%b addr=%0d tw=%0d stage=%0d busy=%b, expected cyc=%0d kind=%b addr=%0d tw=%0d stage=%0d busy=%b",
                   cyc, kd, address, twiddle_idx, stage, busy,
                   x.cyc, x.kind, x.addr, x.tw, x.stg, x.bsy);
        end
        if (x.hand_addr >= 0) begin
          tests++;
          if (address !== 10'(x.hand_addr)) begin
            fails++;
            $display("FAIL hand_addr cyc=%0d got %0d expected %0d", cyc, address, x.hand_addr);
          end
        end
        if (x.hand_tw >= 0) begin
          tests++;
          if (twiddle_idx !== 8'(x.hand_tw)) begin
            fails++;
            $display("FAIL hand_twiddle cyc=%0d got %0d expected %0d", cyc, twiddle_idx, x.hand_tw);
          end
        end
      end
    end
  end

  task automatic check_int(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    tests++;
    if ({fft_start, sram_read_ena, sram_write_ena, bfly_start, done, busy,
         address, twiddle_idx, stage} !== '0) begin
      fails++;
      $display("FAIL %s outputs nonzero: fs=%b rd=%b wr=%b bs=%b done=%b busy=%b addr=%0d tw=%0d stage=%0d, expected all 0",
               nm, fft_start, sram_read_ena, sram_write_ena, bfly_start, done,
               busy, address, twiddle_idx, stage);
    end
  endtask

  // Issue one transform (start sampled at the next edge) and walk it out.
  task automatic go(input int abort_b);
    int e;
    e = cyc + 1;
    build(e, abort_b);
    rd_cnt = 0;
    wr_cnt = 0;
    start  = 1'b1;
    rst    = 1'b0;
    do begin
      @(negedge clk);
      bfly_done = !lo.exists(cyc);
      start     = pulse_at.exists(cyc - e);
      if (cyc == abort_abs) rst = 1'b1;
    end while (cyc != done_abs && cyc != abort_abs);
    start     = 1'b0;
    bfly_done = 1'b1;
    @(negedge clk);
    check_idle(abort_b >= 0 ? "after_abort" : "after_done");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_int("queue_drained", q.size(), 0);
    if (abort_b >= 0) begin
      check_int("abort_reads",  rd_cnt, 2 * (abort_b + 1));
      check_int("abort_writes", wr_cnt, 2 * abort_b + 1);
    end else begin
      check_int("read_strobes",  rd_cnt, 4608);
      check_int("write_strobes", wr_cnt, 4608);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b1;
    bfly_done = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_idle("reset_hold_start");
    end
    go(-1);
    stall_of[0]   = 10;
    stall_of[777] = 3;
    go(-1);
    stall_of.delete();
    go(4 * NB);
    pulse_at[2]     = 1'b1;
    pulse_at[3]     = 1'b1;
    pulse_at[500]   = 1'b1;
    pulse_at[11520] = 1'b1;
    go(-1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
